meas_seq: RTL and testbench

Measurement sequencer for the capacitive paper-count frequency meter. It commands the gate-based frequency counter one gate at a time and collects NSAMP square-wave counts per request. A zero-paper calibration run stores a baseline count; a measurement run averages its samples and classifies the average against thresholds spaced STEP below that baseline. The output is a paper count (0–9) for the BCD/display path, plus busy, valid and error status.

---
 rtl/meas_pkg.sv | 26 ++
 rtl/meas_classify.sv | 62 ++++++
 rtl/meas_seq.sv | 170 +++++++++++++++++
 tb/tb_meas_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
// Shared types and constants for the paper-count measurement sequencer.
package meas_pkg;

  localparam int CNT_W = 28;

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOCAL   = 2'b10;

  localparam logic [3:0] MAX_PAPER = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_AVG,
    ST_CAL_STORE,
    ST_CLASSIFY,
    ST_DONE
  } state_t;

  typedef enum logic {
    MODE_CAL,
    MODE_MEAS
  } mode_t;

endpackage

// File: rtl/meas_classify.sv
// Threshold walker: counts how many STEP-spaced thresholds below the
// baseline the averaged count reaches, one comparison per clock.
module meas_classify
  import meas_pkg::*;
#(
  parameter logic [CNT_W-1:0] STEP = 28'd100
) (
  input  logic             clk_6M,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_avg,
  input  logic [CNT_W-1:0] i_base,
  output logic             o_done,
  output logic [3:0]       o_k
);

  logic             r_run;
  logic             r_zero;
  logic [CNT_W-1:0] r_avg;
  logic [CNT_W-1:0] r_thr;
  logic [3:0]       r_k;

  logic             w_hit;
  logic             w_guard;
  logic             w_last;
  logic [3:0]       w_kInc;

  // A hit means the average sits at or below the current threshold.
  // The guard stops the walk once the next threshold would drop below
  // STEP, so thresholds never wrap around zero.
  assign w_kInc  = r_k + 4'd1;
  assign w_hit   = r_run && !r_zero && (r_avg <= r_thr) && (r_k < MAX_PAPER);
  assign w_guard = {1'b0, r_thr} < {STEP, 1'b0};
  assign w_last  = (w_kInc == MAX_PAPER) || w_guard;
  assign o_done  = r_run && (!w_hit || w_last);
  assign o_k     = w_hit ? w_kInc : r_k;

  // Load the first threshold on start, then step down while hits continue.
  always_ff @(posedge clk_6M or negedge reset_n) begin
    if (!reset_n) begin
      r_run  <= 1'b0;
      r_zero <= 1'b0;
      r_avg  <= '0;
      r_thr  <= '0;
      r_k    <= '0;
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_zero <= (i_base < STEP);
      r_avg  <= i_avg;
      r_thr  <= i_base - STEP;
      r_k    <= '0;
    end else if (r_run) begin
      if (o_done) begin
        r_run <= 1'b0;
      end else begin
        r_k   <= w_kInc;
        r_thr <= r_thr - STEP;
      end
    end
  end

endmodule

// File: rtl/meas_seq.sv
// Measurement sequencer: requests NSAMP gates from the frequency counter,
// averages the counts, and either stores a calibration baseline or
// classifies the average into a paper count.
module meas_seq
  import meas_pkg::*;
#(
  parameter int               NSAMP   = 4,
  parameter logic [CNT_W-1:0] STEP    = 28'd100,
  parameter logic [CNT_W-1:0] TIMEOUT = 28'd15_000_000
) (
  input  logic             clk_6M,
  input  logic             reset_n,
  input  logic             key_cal,
  input  logic             key_meas,
  output logic             meas_start,
  input  logic             meas_done,
  input  logic [CNT_W-1:0] meas_cnt,
  output logic             busy,
  output logic             cal_valid,
  output logic [7:0]       result,
  output logic             result_valid,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int               SUM_W   = CNT_W + 4;
  localparam int               SHIFT   = $clog2(NSAMP);
  localparam logic [4:0]       NSAMP_L = 5'(NSAMP);
  localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT - CNT_W'(1);

  state_t           r_state;
  mode_t            r_mode;
  logic [SUM_W-1:0] r_sum;
  logic [4:0]       r_idx;
  logic [CNT_W-1:0] r_tcnt;
  logic [CNT_W-1:0] r_avg;
  logic [CNT_W-1:0] r_base;
  logic             r_measStart;
  logic             r_busy;
  logic             r_calValid;
  logic [7:0]       r_result;
  logic             r_resultValid;
  logic             r_err;
  logic [1:0]       r_errCode;

  logic [CNT_W-1:0] w_avg;
  logic             w_clsStart;
  logic             w_clsDone;
  logic [3:0]       w_clsK;

  assign w_avg      = CNT_W'(r_sum >> SHIFT);
  assign w_clsStart = (r_state == ST_AVG) && (r_mode == MODE_MEAS);

  meas_classify #(
    .STEP(STEP)
  ) u_classify (
    .clk_6M (clk_6M),
    .reset_n(reset_n),
    .i_start(w_clsStart),
    .i_avg  (w_avg),
    .i_base (r_base),
    .o_done (w_clsDone),
    .o_k    (w_clsK)
  );

  assign meas_start   = r_measStart;
  assign busy         = r_busy;
  assign cal_valid    = r_calValid;
  assign result       = r_result;
  assign result_valid = r_resultValid;
  assign err          = r_err;
  assign err_code     = r_errCode;

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clk_6M or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_CAL;
      r_sum         <= '0;
      r_idx         <= '0;
      r_tcnt        <= '0;
      r_avg         <= '0;
      r_base        <= '0;
      r_measStart   <= 1'b0;
      r_busy        <= 1'b0;
      r_calValid    <= 1'b0;
      r_result      <= '0;
      r_resultValid <= 1'b0;
      r_err         <= 1'b0;
      r_errCode     <= 2'b00;
    end else begin
      r_measStart   <= 1'b0;
      r_resultValid <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (key_cal) begin
            r_mode      <= MODE_CAL;
            r_sum       <= '0;
            r_idx       <= '0;
            r_measStart <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_REQ;
          end else if (key_meas) begin
            if (r_calValid) begin
              r_mode      <= MODE_MEAS;
              r_sum       <= '0;
              r_idx       <= '0;
              r_measStart <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= ST_REQ;
            end else begin
              r_err     <= 1'b1;
              r_errCode <= ERR_NOCAL;
            end
          end
        end
        ST_REQ: begin
          r_tcnt  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (meas_done) begin
            r_sum <= r_sum + SUM_W'(meas_cnt);
            r_idx <= r_idx + 5'd1;
            if ((r_idx + 5'd1) < NSAMP_L) begin
              r_measStart <= 1'b1;
              r_state     <= ST_REQ;
            end else begin
              r_state <= ST_AVG;
            end
          end else if (r_tcnt == TO_LAST) begin
            r_err     <= 1'b1;
            r_errCode <= ERR_TIMEOUT;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_tcnt <= r_tcnt + CNT_W'(1);
          end
        end
        ST_AVG: begin
          r_avg   <= w_avg;
          r_state <= (r_mode == MODE_CAL) ? ST_CAL_STORE : ST_CLASSIFY;
        end
        ST_CAL_STORE: begin
          r_base     <= r_avg;
          r_calValid <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        ST_CLASSIFY: begin
          if (w_clsDone) begin
            r_result      <= {4'd0, w_clsK};
            r_resultValid <= 1'b1;
            r_state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meas_seq.sv
// Testbench for meas_seq: drives calibration/measurement runs with a
// simple counter responder and compares against an arithmetic model.
module tb_meas_seq;

  localparam int NSAMP = 4;
  localparam int STEP  = 100;
  localparam int TO    = 200;

  logic        clk_6M = 1'b0;
  logic        reset_n = 1'b0;
  logic        key_cal = 1'b0;
  logic        key_meas = 1'b0;
  logic        meas_done = 1'b0;
  logic [27:0] meas_cnt = '0;
  logic        meas_start;
  logic        busy;
  logic        cal_valid;
  logic [7:0]  result;
  logic        result_valid;
  logic        err;
  logic [1:0]  err_code;

  int assertCount = 0;
  int failCount   = 0;
  int startCount  = 0;
  int rvCount     = 0;

  logic [27:0] cnts [NSAMP];
  longint      modelBase = 0;
  int          lastResult = 0;

  always #5 clk_6M = ~clk_6M;

  meas_seq #(
    .NSAMP  (NSAMP),
    .STEP   (28'(STEP)),
    .TIMEOUT(28'(TO))
  ) dut (
    .clk_6M      (clk_6M),
    .reset_n     (reset_n),
    .key_cal     (key_cal),
    .key_meas    (key_meas),
    .meas_start  (meas_start),
    .meas_done   (meas_done),
    .meas_cnt    (meas_cnt),
    .busy        (busy),
    .cal_valid   (cal_valid),
    .result      (result),
    .result_valid(result_valid),
    .err         (err),
    .err_code    (err_code)
  );

  // Count one-cycle output pulses mid-cycle.
  always @(negedge clk_6M) begin
    if (meas_start === 1'b1) startCount++;
    if (result_valid === 1'b1) rvCount++;
  end

  // Paper count from the rules: one sheet per full STEP below the baseline,
  // capped at 9, and capped where the next threshold would fall below STEP.
  function automatic longint capOf(longint b);
    longint cap;
    cap = b / STEP - 1;
    if (cap < 1) cap = 1;
    return cap;
  endfunction

  function automatic int expPaper(longint b, longint a);
    longint nat;
    longint cap;
    if (b < STEP || a > b - STEP) return 0;
    nat = (b - a) / STEP;
    if (nat > 9) nat = 9;
    cap = capOf(b);
    return int'((nat < cap) ? nat : cap);
  endfunction

  function automatic int expCycles(longint b, longint a);
    int k;
    k = expPaper(b, a);
    if (k == 0) return 1;
    if (k == 9 || longint'(k) == capOf(b)) return k;
    return k + 1;
  endfunction

  function automatic longint avgOfCnts();
    longint sum;
    sum = 0;
    for (int i = 0; i < NSAMP; i++) sum += longint'(cnts[i]);
    return sum / NSAMP;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic fillCnts(input int value, input int noise);
    for (int i = 0; i < NSAMP; i++) begin
      if (noise > 0)
        cnts[i] = 28'(value + int'($urandom_range(0, 2 * noise)) - noise);
      else
        cnts[i] = 28'(value);
    end
  endtask

  // Start a run with the given keys and answer each gate request.
  task automatic applyStimulus(input bit kc, input bit km, input bit strayDone, input bit strayKey);
    key_cal  = kc;
    key_meas = km;
    step();
    key_cal  = 1'b0;
    key_meas = 1'b0;
    for (int i = 0; i < NSAMP; i++) begin
      checkOutput("meas_start", 64'(meas_start), 64'd1);
      if (strayDone && i == 0) begin
        meas_done = 1'b1;
        meas_cnt  = 28'd9999;
      end
      step();
      meas_done = 1'b0;
      if (strayKey && i == 1) begin
        key_meas = 1'b1;
        step();
        key_meas = 1'b0;
      end
      repeat ($urandom_range(0, 3)) step();
      meas_done = 1'b1;
      meas_cnt  = cnts[i];
      step();
      meas_done = 1'b0;
    end
  endtask

  task automatic calRun(input bit alsoMeasKey, input bit strayDone);
    int     s0;
    int     r0;
    longint avg;
    avg = avgOfCnts();
    s0  = startCount;
    r0  = rvCount;
    applyStimulus(1'b1, alsoMeasKey, strayDone, 1'b0);
    step();
    checkOutput("cal_busy_store", 64'(busy), 64'd1);
    step();
    checkOutput("cal_valid", 64'(cal_valid), 64'd1);
    checkOutput("cal_busy_after", 64'(busy), 64'd0);
    step();
    checkOutput("cal_no_rv", 64'(rvCount - r0), 64'd0);
    checkOutput("cal_starts", 64'(startCount - s0), 64'(NSAMP));
    modelBase = avg;
  endtask

  task automatic measRun(input bit strayKey);
    int     s0;
    int     r0;
    int     k;
    int     cyc;
    int     lat;
    longint avg;
    avg = avgOfCnts();
    k   = expPaper(modelBase, avg);
    cyc = expCycles(modelBase, avg);
    s0  = startCount;
    r0  = rvCount;
    applyStimulus(1'b0, 1'b1, 1'b0, strayKey);
    lat = 0;
    for (int c = 0; c < 20 && result_valid !== 1'b1; c++) begin
      step();
      lat++;
    end
    checkOutput("rv_latency", 64'(lat), 64'(cyc + 1));
    checkOutput("result", 64'(result), 64'(k));
    checkOutput("busy_in_done", 64'(busy), 64'd1);
    step();
    checkOutput("busy_after", 64'(busy), 64'd0);
    step();
    step();
    checkOutput("rv_pulses", 64'(rvCount - r0), 64'd1);
    checkOutput("starts", 64'(startCount - s0), 64'(NSAMP));
    lastResult = k;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_meas_start"}, 64'(meas_start), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_cal_valid"}, 64'(cal_valid), 64'd0);
    checkOutput({tag, "_result"}, 64'(result), 64'd0);
    checkOutput({tag, "_result_valid"}, 64'(result_valid), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
    checkOutput({tag, "_err_code"}, 64'(err_code), 64'd0);
  endtask

  task automatic noCalCheck();
    int s0;
    s0 = startCount;
    key_meas = 1'b1;
    step();
    key_meas = 1'b0;
    checkOutput("nocal_err", 64'(err), 64'd1);
    checkOutput("nocal_code", 64'(err_code), 64'd2);
    checkOutput("nocal_busy", 64'(busy), 64'd0);
    step();
    checkOutput("nocal_err_pulse", 64'(err), 64'd0);
    checkOutput("nocal_code_hold", 64'(err_code), 64'd2);
    step();
    checkOutput("nocal_starts", 64'(startCount - s0), 64'd0);
  endtask

  initial begin
    int lat;
    int r0;

    // Reset state
    repeat (3) step();
    checkResetOutputs("reset");
    reset_n = 1'b1;
    step();

    // Measure before any calibration
    noCalCheck();

    // Calibration with a stray meas_done during the first REQ
    cnts[0] = 28'd5000;
    cnts[1] = 28'd5004;
    cnts[2] = 28'd4996;
    cnts[3] = 28'd5000;
    calRun(1'b0, 1'b1);

    // Fixed measurements, one with a key press during WAIT
    fillCnts(4700, 0);
    measRun(1'b1);
    fillCnts(5100, 0);
    measRun(1'b0);
    fillCnts(3000, 0);
    measRun(1'b0);

    // Randomized measurements around the 5000 baseline
    for (int n = 0; n < 6; n++) begin
      fillCnts(5150 - int'($urandom_range(0, 1300)), 3);
      measRun(1'b0);
    end

    // Both keys together recalibrate to a low baseline near the guard
    cnts[0] = 28'd260;
    cnts[1] = 28'd262;
    cnts[2] = 28'd258;
    cnts[3] = 28'd261;
    calRun(1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      fillCnts(int'($urandom_range(0, 300)), 0);
      measRun(1'b0);
    end

    // Baseline below one STEP always classifies as zero
    fillCnts(50, 0);
    calRun(1'b0, 1'b0);
    fillCnts(0, 0);
    measRun(1'b0);

    // Back to a normal baseline, then time out a gate
    fillCnts(5000, 0);
    calRun(1'b0, 1'b0);
    fillCnts(4500, 2);
    measRun(1'b0);
    r0 = rvCount;
    key_meas = 1'b1;
    step();
    key_meas = 1'b0;
    checkOutput("to_start", 64'(meas_start), 64'd1);
    lat = 0;
    for (int c = 0; c < TO + 50 && err !== 1'b1; c++) begin
      step();
      lat++;
    end
    checkOutput("to_latency", 64'(lat), 64'(TO + 1));
    checkOutput("to_code", 64'(err_code), 64'd1);
    checkOutput("to_busy", 64'(busy), 64'd0);
    checkOutput("to_result", 64'(result), 64'(lastResult));
    step();
    checkOutput("to_err_pulse", 64'(err), 64'd0);
    checkOutput("to_no_rv", 64'(rvCount - r0), 64'd0);

    // Reset during the third sample's WAIT
    key_cal = 1'b1;
    step();
    key_cal = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      meas_done = 1'b1;
      meas_cnt  = 28'd5000;
      step();
      meas_done = 1'b0;
    end
    step();
    checkOutput("pre_reset_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midrun");
    step();
    step();
    reset_n = 1'b1;
    step();
    noCalCheck();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
